// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the 4:1 mux select sequencer.
//   state_t          : sequencer FSM states
//   SEL_W / LANES    : select width and number of mux lanes
//   first_sel/last_sel : select index at the start and end of a word
package mux_sel_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int SEL_W = 2;
  localparam int LANES = 4;

  function automatic logic [SEL_W-1:0] first_sel(input bit lsb_first);
    return lsb_first ? 2'd0 : 2'd3;
  endfunction

  function automatic logic [SEL_W-1:0] last_sel(input bit lsb_first);
    return lsb_first ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/mux_sel_sequencer.sv
// Upstream control stage for a 4:1 bit mux: captures a 4-bit word on a
// valid/ready handshake, holds it on the mux data inputs and walks the
// select through all four lanes, returning the mux output as a serial
// valid/ready/last stream.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/ready/data : parallel word input handshake
//   mux_data, mux_sel   : registered drive of the external mux
//   mux_out             : mux output (combinational return path)
//   ser_valid/ready/bit/last : serial output handshake
//   busy                : high while shifting or in the inter-word gap
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter bit LSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_data,
  output logic [LANES-1:0] mux_data,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_FIRST = first_sel(LSB_FIRST);
  // Adding 3 modulo 4 is a decrement for MSB-first order.
  localparam logic [SEL_W-1:0] SEL_STEP  = LSB_FIRST ? 2'd1 : 2'd3;
  localparam bit               NO_GAP    = (GAP_CYCLES == 0);
  localparam logic [3:0]       GAP_LOAD  = NO_GAP ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic       rdy_en;     // holds in_ready low for the first cycle out of reset
  logic [1:0] bit_cnt;
  logic [3:0] gap_cnt;
  logic       bit_take, word_end, load;

  always_comb begin
    ser_valid = (state == SHIFT);
    ser_last  = (state == SHIFT) && (bit_cnt == 2'd3);
    busy      = (state != IDLE);
    ser_bit   = mux_out;
    bit_take  = ser_valid && ser_ready;
    word_end  = bit_take && (bit_cnt == 2'd3);
    // With no gap, the last-bit cycle doubles as the accept slot for the
    // next word so back-to-back words stream without a bubble.
    in_ready  = ((state == IDLE) && rdy_en) || (word_end && NO_GAP);
    load      = in_valid && in_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load) state_nxt = SHIFT;
      SHIFT: begin
        if (word_end) begin
          if (load)        state_nxt = SHIFT;
          else if (NO_GAP) state_nxt = IDLE;
          else             state_nxt = GAP;
        end
      end
      GAP:   if (gap_cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_en   <= 1'b0;
      mux_data <= '0;
      mux_sel  <= SEL_FIRST;
      bit_cnt  <= 2'd0;
      gap_cnt  <= 4'd0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (load) begin
        mux_data <= in_data;
        mux_sel  <= SEL_FIRST;
        bit_cnt  <= 2'd0;
      end else if (bit_take) begin
        bit_cnt <= bit_cnt + 2'd1;
        // Select never wraps mid-word; only a new load returns it to the start.
        if (!word_end) mux_sel <= mux_sel + SEL_STEP;
      end
      if (word_end && !NO_GAP && !load)
        gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != 4'd0)
        gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;

  typedef struct {
    logic       b;
    logic       last;
    logic [1:0] sel;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [2:0]      in_valid, in_ready, mux_out, ser_valid, ser_ready, ser_bit, ser_last, busy;
  logic [2:0][3:0] in_data, mux_data;
  logic [2:0][1:0] mux_sel;

  int tests = 0;
  int fails = 0;

  // Instance 0: LSB first, no gap. 1: MSB first, no gap. 2: LSB first, gap 2.
  for (genvar i = 0; i < 3; i++) begin : g_dut
    mux_sel_sequencer #(.LSB_FIRST(i != 1), .GAP_CYCLES(i == 2 ? 2 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[i]), .in_ready(in_ready[i]), .in_data(in_data[i]),
      .mux_data(mux_data[i]), .mux_sel(mux_sel[i]), .mux_out(mux_out[i]),
      .ser_valid(ser_valid[i]), .ser_ready(ser_ready[i]), .ser_bit(ser_bit[i]),
      .ser_last(ser_last[i]), .busy(busy[i])
    );
    // The 4:1 bit mux closing the loop.
    assign mux_out[i] = mux_data[i][mux_sel[i]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        tests++; if (in_ready[d] !== 1'b0) begin fails++; $display("FAIL reset_in_ready d%0d: got %b want 0", d, in_ready[d]); end
        tests++; if (ser_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_ser_valid d%0d: got %b want 0", d, ser_valid[d]); end
        tests++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL reset_busy d%0d: got %b want 0", d, busy[d]); end
        tests++; if (ser_last[d] !== 1'b0) begin fails++; $display("FAIL reset_ser_last d%0d: got %b want 0", d, ser_last[d]); end
        tests++; if (mux_data[d] !== 4'h0) begin fails++; $display("FAIL reset_mux_data d%0d: got %h want 0", d, mux_data[d]); end
        tests++; if (mux_sel[d] !== ((d == 1) ? 2'd3 : 2'd0)) begin fails++; $display("FAIL reset_mux_sel d%0d: got %0d want %0d", d, mux_sel[d], (d == 1) ? 3 : 0); end
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++; if (in_ready[d] !== 1'b0) begin fails++; $display("FAIL release_in_ready_lo d%0d: got %b want 0", d, in_ready[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++; if (in_ready[d] !== 1'b1) begin fails++; $display("FAIL release_in_ready_hi d%0d: got %b want 1", d, in_ready[d]); end
    end
    // Mid-word reset on instance 0: drop the word after two bits.
    @(posedge clk); #1 in_valid[0] = 1'b1; in_data[0] = 4'b1011;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests++; if (ser_valid[0] !== 1'b0) begin fails++; $display("FAIL midreset_ser_valid: got %b want 0", ser_valid[0]); end
      tests++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL midreset_in_ready: got %b want 0", in_ready[0]); end
      tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
      tests++; if (mux_sel[0] !== 2'd0) begin fails++; $display("FAIL midreset_mux_sel: got %0d want 0", mux_sel[0]); end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL midreset_release_lo: got %b want 0", in_ready[0]); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++; if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL midreset_release_hi c%0d: got %b want 1", c, in_ready[0]); end
      tests++; if (ser_valid[0] !== 1'b0) begin fails++; $display("FAIL midreset_no_valid c%0d: got %b want 0", c, ser_valid[0]); end
    end
  endtask

  // One word 4'b1011 through instance d; d=0 is LSB first, d=1 MSB first.
  task automatic test_single(input int d);
    bit e_lsb[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit e_msb[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic eb;
    logic [1:0] es;
    @(posedge clk); #1 in_valid[d] = 1'b1; in_data[d] = 4'b1011; ser_ready[d] = 1'b1;
    @(negedge clk);
    tests++; if (in_ready[d] !== 1'b1) begin fails++; $display("FAIL single_accept d%0d: got %b want 1", d, in_ready[d]); end
    @(posedge clk); #1 in_valid[d] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      eb = (d == 1) ? e_msb[k] : e_lsb[k];
      es = (d == 1) ? 2'(3 - k) : 2'(k);
      tests++; if (ser_valid[d] !== 1'b1) begin fails++; $display("FAIL single_valid d%0d k%0d: got %b want 1", d, k, ser_valid[d]); end
      tests++; if (ser_bit[d] !== eb) begin fails++; $display("FAIL single_bit d%0d k%0d: got %b want %b", d, k, ser_bit[d], eb); end
      tests++; if (ser_last[d] !== (k == 3)) begin fails++; $display("FAIL single_last d%0d k%0d: got %b want %b", d, k, ser_last[d], k == 3); end
      tests++; if (mux_sel[d] !== es) begin fails++; $display("FAIL single_sel d%0d k%0d: got %0d want %0d", d, k, mux_sel[d], es); end
      @(posedge clk);
    end
    @(negedge clk);
    tests++; if (ser_valid[d] !== 1'b0) begin fails++; $display("FAIL single_end d%0d: got %b want 0", d, ser_valid[d]); end
  endtask

  task automatic test_backpressure();
    bit r[7]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int idx[7] = '{0, 1, 2, 2, 2, 2, 3};
    logic [3:0] w = 4'b0100;
    @(posedge clk); #1 in_valid[0] = 1'b1; in_data[0] = w;
    @(posedge clk); #1 in_valid[0] = 1'b0; in_data[0] = 4'hF; ser_ready[0] = r[0];
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      tests++; if (ser_valid[0] !== 1'b1) begin fails++; $display("FAIL bp_valid c%0d: got %b want 1", c, ser_valid[0]); end
      tests++; if (ser_bit[0] !== w[idx[c]]) begin fails++; $display("FAIL bp_bit c%0d: got %b want %b", c, ser_bit[0], w[idx[c]]); end
      tests++; if (mux_sel[0] !== 2'(idx[c])) begin fails++; $display("FAIL bp_sel c%0d: got %0d want %0d", c, mux_sel[0], idx[c]); end
      tests++; if (ser_last[0] !== (idx[c] == 3)) begin fails++; $display("FAIL bp_last c%0d: got %b want %b", c, ser_last[0], idx[c] == 3); end
      @(posedge clk); #1 ser_ready[0] = (c < 6) ? r[c + 1] : 1'b1;
    end
    @(negedge clk);
    tests++; if (ser_valid[0] !== 1'b0) begin fails++; $display("FAIL bp_end: got %b want 0", ser_valid[0]); end
  endtask

  task automatic test_back_to_back();
    bit e[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1 in_valid[0] = 1'b1; in_data[0] = 4'hA; ser_ready[0] = 1'b1;
    @(negedge clk);
    tests++; if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b_accept: got %b want 1", in_ready[0]); end
    @(posedge clk); #1 in_data[0] = 4'h5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++; if (ser_valid[0] !== 1'b1) begin fails++; $display("FAIL b2b_valid k%0d: got %b want 1", k, ser_valid[0]); end
      tests++; if (ser_bit[0] !== e[k]) begin fails++; $display("FAIL b2b_bit k%0d: got %b want %b", k, ser_bit[0], e[k]); end
      tests++; if (ser_last[0] !== (k % 4 == 3)) begin fails++; $display("FAIL b2b_last k%0d: got %b want %b", k, ser_last[0], k % 4 == 3); end
      tests++; if (in_ready[0] !== (k % 4 == 3)) begin fails++; $display("FAIL b2b_in_ready k%0d: got %b want %b", k, in_ready[0], k % 4 == 3); end
      @(posedge clk); #1;
      if (k == 3) in_valid[0] = 1'b0;
    end
    @(negedge clk);
    tests++; if (ser_valid[0] !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b want 0", ser_valid[0]); end
    tests++; if (mux_data[0] !== 4'h5) begin fails++; $display("FAIL b2b_mux_data: got %h want 5", mux_data[0]); end
  endtask

  task automatic test_gap();
    logic [3:0] w1 = 4'h3, w2 = 4'h6;
    logic ev, eb, eby, er;
    logic [3:0] ed;
    @(posedge clk); #1 in_valid[2] = 1'b1; in_data[2] = w1; ser_ready[2] = 1'b1;
    @(negedge clk);
    tests++; if (in_ready[2] !== 1'b1) begin fails++; $display("FAIL gap_accept: got %b want 1", in_ready[2]); end
    @(posedge clk); #1 in_data[2] = 4'hF;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      ev  = (c <= 3) || (c >= 7);
      eby = (c != 6);
      er  = (c == 6);
      ed  = (c >= 7) ? w2 : w1;
      eb  = (c <= 3) ? w1[c] : (c >= 7) ? w2[c - 7] : ser_bit[2];
      tests++; if (ser_valid[2] !== ev) begin fails++; $display("FAIL gap_valid c%0d: got %b want %b", c, ser_valid[2], ev); end
      tests++; if (busy[2] !== eby) begin fails++; $display("FAIL gap_busy c%0d: got %b want %b", c, busy[2], eby); end
      tests++; if (in_ready[2] !== er) begin fails++; $display("FAIL gap_in_ready c%0d: got %b want %b", c, in_ready[2], er); end
      tests++; if (mux_data[2] !== ed) begin fails++; $display("FAIL gap_mux_data c%0d: got %h want %h", c, mux_data[2], ed); end
      if (ev) begin
        tests++; if (ser_bit[2] !== eb) begin fails++; $display("FAIL gap_bit c%0d: got %b want %b", c, ser_bit[2], eb); end
      end
      @(posedge clk); #1;
      if (c == 5) in_data[2] = w2;
      if (c == 6) in_valid[2] = 1'b0;
    end
    repeat (4) @(posedge clk);
  endtask

  // Random traffic against a queue model: each accepted word expands to four
  // expected (bit, last, sel) entries; after a word drains the model waits
  // out the configured gap before it is ready again.
  task automatic test_random(input int d, input int n);
    exp_t q[$];
    exp_t e;
    int   gap_left = 0;
    int   gapc = (d == 2) ? 2 : 0;
    bit   lsb = (d != 1);
    logic exp_rdy, exp_busy;
    int   pos;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      in_valid[d]  = 1'($urandom_range(0, 1));
      in_data[d]   = 4'($urandom);
      ser_ready[d] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy  = (q.size() == 0 && gap_left == 0) || (gapc == 0 && q.size() == 1 && ser_ready[d]);
      exp_busy = (q.size() != 0) || (gap_left != 0);
      tests++; if (in_ready[d] !== exp_rdy) begin fails++; $display("FAIL rnd_in_ready d%0d c%0d: got %b want %b", d, c, in_ready[d], exp_rdy); end
      tests++; if (ser_valid[d] !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid d%0d c%0d: got %b want %b", d, c, ser_valid[d], q.size() != 0); end
      tests++; if (busy[d] !== exp_busy) begin fails++; $display("FAIL rnd_busy d%0d c%0d: got %b want %b", d, c, busy[d], exp_busy); end
      if (q.size() != 0) begin
        tests++; if (ser_bit[d] !== q[0].b) begin fails++; $display("FAIL rnd_bit d%0d c%0d: got %b want %b", d, c, ser_bit[d], q[0].b); end
        tests++; if (ser_last[d] !== q[0].last) begin fails++; $display("FAIL rnd_last d%0d c%0d: got %b want %b", d, c, ser_last[d], q[0].last); end
        tests++; if (mux_sel[d] !== q[0].sel) begin fails++; $display("FAIL rnd_sel d%0d c%0d: got %0d want %0d", d, c, mux_sel[d], q[0].sel); end
      end
      if (q.size() == 0 && gap_left > 0) gap_left--;
      if (q.size() != 0 && ser_ready[d]) begin
        void'(q.pop_front());
        if (q.size() == 0) gap_left = gapc;
      end
      if (in_valid[d] && exp_rdy) begin
        gap_left = 0;
        for (int k = 0; k < 4; k++) begin
          pos    = lsb ? k : 3 - k;
          e.b    = in_data[d][pos];
          e.last = (k == 3);
          e.sel  = 2'(pos);
          q.push_back(e);
        end
      end
    end
    @(posedge clk); #1 in_valid[d] = 1'b0; ser_ready[d] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL rnd_drain d%0d: got %b want 0", d, busy[d]); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    ser_ready = 3'b111;
    test_reset();
    test_single(0);
    test_single(1);
    test_backpressure();
    test_back_to_back();
    test_gap();
    test_random(0, 300);
    test_random(1, 300);
    test_random(2, 300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the 4:1 bit multiplexer.
- Accepts a 4-bit parallel word on a valid/ready handshake and holds it on the mux data inputs.
- Steps the 2-bit select through all four lanes and re-presents the mux output as a serial bit stream with its own valid/ready/last handshake.
- Combined with the mux, it forms a 4-bit parallel-to-serial converter.

Parameters:
- LSB_FIRST, 1, 1: select order 0,1,2,3. 0: select order 3,2,1,0.
- GAP_CYCLES, 0, idle cycles inserted after each word's last bit before in_ready reasserts. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  parallel word valid
- in_ready  output  1  sequencer can accept a word
- in_data  input  4  parallel word
- mux_data  output  4  registered word, drives the mux data_in
- mux_sel  output  2  registered select, drives the mux sel
- mux_out  input  1  mux output, combinational return path
- ser_valid  output  1  ser_bit is valid
- ser_ready  input  1  downstream accepts ser_bit
- ser_bit  output  1  equals mux_out (combinational pass-through)
- ser_last  output  1  current bit is the word's 4th bit
- busy  output  1  high in SHIFT or GAP

Behaviour:
- Clocking and reset:
  - One clock domain; all state is on rising clk.
  - rst_n low asynchronously forces state=IDLE, mux_data=0, mux_sel=(LSB_FIRST ? 0 : 3), bit_cnt=0, gap_cnt=0.
  - Reset value of every output: in_ready=0, ser_valid=0, ser_last=0, busy=0, ser_bit=mux_out.
  - in_ready rises the first clk after rst_n deasserts; it is registered and reset to 0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid & in_ready: mux_data<=in_data, mux_sel<=first index, bit_cnt<=0, go to SHIFT.
  - First ser_valid appears the cycle after the accept (latency 1).
- SHIFT:
  - ser_valid=1, ser_bit=mux_out, ser_last=(bit_cnt==3).
  - On ser_valid & ser_ready: bit_cnt+1 and mux_sel steps (+1 if LSB_FIRST, else -1, modulo 4).
  - If ser_ready is low, mux_sel, mux_data and ser_bit hold stable indefinitely.
  - Accept with bit_cnt==3:
    - GAP_CYCLES==0: in_ready=1 combinationally in the same cycle. A simultaneous in_valid loads the next word and SHIFT continues with no bubble. Otherwise go to IDLE.
    - GAP_CYCLES>0: go to GAP with gap_cnt<=GAP_CYCLES-1.
- GAP:
  - ser_valid=0, in_ready=0.
  - gap_cnt decrements; when 0, go to IDLE.
- Boundaries and corner cases:
  - in_valid while busy (outside the back-to-back slot) is ignored; the word is not captured.
  - mux_data only changes on an accepted word; it is never cleared between words.
  - Select wrap-around, MSB-first mode: 0 steps to 3 only on a new word load, never mid-word.
  - Reset mid-word drops the partial word with no further ser_valid.
  - Output in_ready = (state==IDLE) | (state==SHIFT & bit_cnt==3 & ser_ready & GAP_CYCLES==0).

Decomposition:
- Shared package contents:
  - State enum {IDLE, SHIFT, GAP}.
  - Constants SEL_W=2, LANES=4.
  - First/last select index function of LSB_FIRST.
- No sub-module. The existing mux is instantiated alongside, at the parent level, not inside this block.
- The bench instantiates the sequencer plus the mux to close the mux_out loop.

Test Plan:
- Reset: rst_n low mid-word for 2 cycles -> ser_valid=0, in_ready=0, busy=0, mux_sel=0 (LSB_FIRST=1). First cycle after release in_ready=0, then 1.
- Single word LSB_FIRST=1: in_data=4'b1011, ser_ready=1 -> ser_bit sequence 1,1,0,1 on 4 consecutive cycles starting 1 cycle after accept, ser_last only on the 4th.
- MSB_FIRST (LSB_FIRST=0): in_data=4'b1011 -> sequence 1,0,1,1; mux_sel 3,2,1,0.
- Backpressure: ser_ready low for 3 cycles on bit 2 of 4'b0100 -> ser_valid stays 1, mux_sel=2, ser_bit=1 held; resumes correctly.
- Back-to-back, GAP_CYCLES=0: words 4'hA then 4'h5 with in_valid held -> 8 contiguous valid bits 0,1,0,1,1,0,1,0 with no idle cycle; in_ready pulses in the last-bit cycle.
- GAP_CYCLES=2: two words -> exactly 2 cycles of ser_valid=0 and busy=1 between ser_last and the next accept; in_valid during GAP not captured.
